// File: rtl/list_feeder.sv
// Packs a valid/ready word stream into 4-word groups for the list adder. One group is staged
// while another is held on buffer. Optional LIST_FEEDER_COUNT_EN adds a running list word count.
module list_feeder #(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] PAD_VALUE = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_W-1:0]      in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_last,
    input  logic                   data_request,
    output logic [3:0][DATA_W-1:0] buffer,
    output logic                   data_available,
    output logic                   group_last
`ifdef LIST_FEEDER_COUNT_EN
    ,
    output logic [15:0]            list_words
`endif
);

    logic [3:0][DATA_W-1:0] staging;
    logic [1:0]             idx;
    logic                   staged_full;
    logic                   stg_last;
    logic [2:0]             stg_n;
    logic                   pending;
    logic                   req_q;
    logic                   run;

    logic accept;
    logic req_rise;
    logic xfer;

    // run holds in_ready low until the first edge after reset release.
    assign in_ready = run & ~staged_full;
    assign accept   = in_valid & in_ready;
    assign req_rise = data_request & ~req_q;
    assign xfer     = staged_full & (pending | req_rise);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            staging        <= '0;
            idx            <= '0;
            staged_full    <= 1'b0;
            stg_last       <= 1'b0;
            stg_n          <= '0;
            pending        <= 1'b0;
            req_q          <= 1'b0;
            run            <= 1'b0;
            buffer         <= '0;
            data_available <= 1'b0;
            group_last     <= 1'b0;
        end else begin
            run   <= 1'b1;
            req_q <= data_request;

            if (xfer) begin
                buffer         <= staging;
                group_last     <= stg_last;
                data_available <= 1'b1;
                staged_full    <= 1'b0;
                pending        <= 1'b0;
            end else begin
                // A rise with nothing staged consumes the current group; the refill follows.
                pending <= pending | req_rise;
                if (req_rise)
                    data_available <= 1'b0;
            end

            // Never coincides with xfer: in_ready is low while staging is full.
            if (accept) begin
                staging[idx] <= in_data;
                for (int i = 0; i < 4; i++)
                    if (in_last && (i > int'(idx)))
                        staging[i] <= PAD_VALUE;
                if (in_last || (idx == 2'd3)) begin
                    staged_full <= 1'b1;
                    stg_last    <= in_last;
                    stg_n       <= {1'b0, idx} + 3'd1;
                    idx         <= '0;
                end else begin
                    idx <= idx + 2'd1;
                end
            end
        end
    end

`ifdef LIST_FEEDER_COUNT_EN
    logic [16:0] cnt_sum;

    // A new list restarts the count once the previous group closed a list.
    assign cnt_sum = {1'b0, (group_last ? 16'd0 : list_words)} + {14'd0, stg_n};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            list_words <= '0;
        end else if (xfer) begin
            list_words <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
        end else if (req_rise && data_available && group_last) begin
            list_words <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_list_feeder.sv
// Directed bench for list_feeder: reset, full/short groups, preload, consume-while-empty,
// held request and mid-fill reset, with immediate-assertion checks.
module tb_list_feeder;

    localparam int DATA_W = 32;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [DATA_W-1:0]      in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic                   in_last;
    logic                   data_request;
    logic [3:0][DATA_W-1:0] buffer;
    logic                   data_available;
    logic                   group_last;
`ifdef LIST_FEEDER_COUNT_EN
    logic [15:0]            list_words;
`endif

    int checks = 0;
    int errors = 0;

    list_feeder #(.DATA_W(DATA_W), .PAD_VALUE('0)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_last        (in_last),
        .data_request   (data_request),
        .buffer         (buffer),
        .data_available (data_available),
        .group_last     (group_last)
`ifdef LIST_FEEDER_COUNT_EN
        ,
        .list_words     (list_words)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [15:0] exp);
`ifdef LIST_FEEDER_COUNT_EN
        chk(tag, 128'(list_words), 128'(exp));
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one word and returns 1 time unit after the edge that accepted it.
    task automatic send(input logic [31:0] w, input logic last);
        int waited;
        waited   = 0;
        in_data  = w;
        in_last  = last;
        in_valid = 1'b1;
        while (!in_ready && waited < 100) begin
            step();
            waited++;
        end
        if (waited >= 100) begin
            checks++;
            errors++;
            $error("FAIL send_timeout word=%0d observed=stalled expected=accepted", w);
        end
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    function automatic logic [127:0] grp(input logic [31:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    initial begin
        rst = 1'b1; in_data = '0; in_valid = 1'b0; in_last = 1'b0; data_request = 1'b0;
        step();
        chk("rst_buffer", buffer, 128'd0);
        chk("rst_da", data_available, 1'b0);
        chk("rst_gl", group_last, 1'b0);
        chk("rst_ready", in_ready, 1'b0);
        chk_cnt("rst_cnt", 16'd0);
        rst = 1'b0;
        step();
        chk("ready_after_rst", in_ready, 1'b1);

        // Single full group with the request held high.
        data_request = 1'b1;
        send(1, 0); send(2, 0); send(3, 0); send(4, 1);
        chk("full_da_early", data_available, 1'b0);
        chk("full_ready_low", in_ready, 1'b0);
        step();
        chk("full_da", data_available, 1'b1);
        chk("full_buf", buffer, grp(1, 2, 3, 4));
        chk("full_gl", group_last, 1'b1);
        chk("full_ready_back", in_ready, 1'b1);
        chk_cnt("full_cnt", 16'd4);

        // Short list padded with zeros, served on a fresh request rise.
        send(7, 0); send(9, 1);
        chk("short_hold_buf", buffer, grp(1, 2, 3, 4));
        data_request = 1'b0; step();
        data_request = 1'b1; step();
        chk("short_buf", buffer, grp(7, 9, 0, 0));
        chk("short_gl", group_last, 1'b1);
        chk("short_da", data_available, 1'b1);
        chk_cnt("short_cnt", 16'd2);

        // Preload: 8-word list, second group staged while first is held.
        data_request = 1'b0; step();
        send(1, 0); send(2, 0); send(3, 0); send(4, 0);
        chk("pre_hold_buf", buffer, grp(7, 9, 0, 0));
        data_request = 1'b1; step();
        chk("pre_g1_buf", buffer, grp(1, 2, 3, 4));
        chk("pre_g1_gl", group_last, 1'b0);
        chk_cnt("pre_g1_cnt", 16'd4);
        data_request = 1'b0;
        send(5, 0); send(6, 0); send(7, 0); send(8, 1);
        chk("pre_g1_still", buffer, grp(1, 2, 3, 4));
        data_request = 1'b1; step();
        chk("pre_g2_buf", buffer, grp(5, 6, 7, 8));
        chk("pre_g2_gl", group_last, 1'b1);
        chk("pre_g2_da", data_available, 1'b1);
        chk_cnt("pre_g2_cnt", 16'd8);

        // Consume with empty staging, then refill.
        data_request = 1'b0; step();
        data_request = 1'b1; step();
        chk("cons_da", data_available, 1'b0);
        chk("cons_buf_held", buffer, grp(5, 6, 7, 8));
        chk_cnt("cons_cnt_clr", 16'd0);
        send(10, 0); send(11, 0); send(12, 0); send(13, 1);
        chk("cons_da_early", data_available, 1'b0);
        step();
        chk("cons_refill_da", data_available, 1'b1);
        chk("cons_refill_buf", buffer, grp(10, 11, 12, 13));
        chk_cnt("cons_refill_cnt", 16'd4);

        // Held request counts once.
        data_request = 1'b0; step();
        data_request = 1'b1;
        for (int w = 20; w < 28; w++) send(w, 0);
        step(); step(); step();
        chk("held_one_xfer", buffer, grp(20, 21, 22, 23));
        chk("held_ready_low", in_ready, 1'b0);
        chk("held_da", data_available, 1'b1);
        chk_cnt("held_cnt1", 16'd4);
        data_request = 1'b0; step();
        data_request = 1'b1; step();
        chk("held_second", buffer, grp(24, 25, 26, 27));
        chk_cnt("held_cnt2", 16'd8);
        send(28, 0); send(29, 0); send(30, 0); send(31, 1);
        data_request = 1'b0; step();
        data_request = 1'b1; step();
        chk("held_third", buffer, grp(28, 29, 30, 31));
        chk("held_third_gl", group_last, 1'b1);
        chk_cnt("held_cnt3", 16'd12);

        // Reset mid-fill discards everything.
        data_request = 1'b0; step();
        send(40, 0); send(41, 0);
        rst = 1'b1; #1;
        chk("mid_rst_da", data_available, 1'b0);
        chk("mid_rst_buf", buffer, 128'd0);
        chk("mid_rst_gl", group_last, 1'b0);
        chk("mid_rst_ready", in_ready, 1'b0);
        step();
        rst = 1'b0;
        send(50, 0); send(51, 0); send(52, 0); send(53, 0);
        step();
        chk("post_rst_nopend", data_available, 1'b0);
        data_request = 1'b1; step();
        chk("post_rst_buf", buffer, grp(50, 51, 52, 53));
        chk("post_rst_gl", group_last, 1'b0);
        chk("post_rst_da", data_available, 1'b1);
        chk_cnt("post_rst_cnt", 16'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
